sd_cmd_phy: RTL and testbench

Serial engine for the SD CMD line, sitting between the card-init/transfer controller FSM and the CMD pad of the SD top level. It serialises a 48-bit command frame with CRC7 and an optional response capture. Responses may be 48-bit or 136-bit; the block checks CRC and timeout on each. All timing is paced by SDCLK edge strobes from the SD clock generator; the pad tri-state is split into oe/out/in at the top level.

---
 rtl/sd_cmd_phy.sv | 159 +++++++++++++++
 tb/tb_sd_cmd_phy.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7 and captures an optional
// 48/136-bit response, with CRC check, NCR timeout and an NCC idle gap.
module sd_cmd_phy #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned GAP_CYC     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sdclk_fall_stb_i,
    input  logic         sdclk_rise_stb_i,
    input  logic         cmd_start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [135:0] resp_o,
    output logic         crc_err_o,
    output logic         timeout_err_o,
    output logic         cmd_oe_o,
    output logic         cmd_out_o,
    input  logic         cmd_in_i
);
    localparam int unsigned MAX_TG  = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned CNT_MAX = (MAX_TG > 136) ? MAX_TG : 136;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE, S_GAP} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_inc;
    logic [CW-1:0]  w_rx_len;
    logic           w_crc_win;
    logic [39:0]    r_tx_sr;
    logic [6:0]     r_crc;
    logic [1:0]     r_type;
    logic [135:0]   r_rx_sr;
    logic           r_crc_err;
    logic           r_to_err;
    logic           r_cmd_oe;
    logic           r_cmd_out;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_rx_len  = (r_type == 2'b10) ? CW'(136) : CW'(48);
    // R2 CRC skips the 8 header bits; 48-bit responses cover their first 40 bits
    assign w_crc_win = (r_type == 2'b10) ? (w_cnt_inc >= CW'(9) && w_cnt_inc <= CW'(128))
                                         : (w_cnt_inc <= CW'(40));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cmd_start_i) w_next = S_TX;
            S_TX:   if (sdclk_fall_stb_i && r_cnt == CW'(48))
                        w_next = (r_type == 2'b00) ? S_DONE : S_WAIT;
            S_WAIT: if (sdclk_rise_stb_i) begin
                        if (!cmd_in_i)                            w_next = S_RX;
                        else if (w_cnt_inc == CW'(TIMEOUT_CYC))   w_next = S_DONE;
                    end
            S_RX:   if (sdclk_rise_stb_i && w_cnt_inc == w_rx_len) w_next = S_DONE;
            S_DONE: w_next = S_GAP;
            S_GAP:  if (sdclk_rise_stb_i && w_cnt_inc == CW'(GAP_CYC)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state != S_IDLE);
        done_o = (r_state == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_tx_sr   <= '0;
            r_crc     <= '0;
            r_type    <= '0;
            r_rx_sr   <= '0;
            r_crc_err <= 1'b0;
            r_to_err  <= 1'b0;
            r_cmd_oe  <= 1'b0;
            r_cmd_out <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_start_i) begin
                    r_type    <= resp_type_i;
                    r_tx_sr   <= {2'b01, cmd_index_i, cmd_arg_i};
                    r_crc     <= '0;
                    r_rx_sr   <= '0;
                    r_crc_err <= 1'b0;
                    r_to_err  <= 1'b0;
                    r_cnt     <= '0;
                end
                S_TX: if (sdclk_fall_stb_i) begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt < CW'(40)) begin
                        r_cmd_oe  <= 1'b1;
                        r_cmd_out <= r_tx_sr[39];
                        r_tx_sr   <= {r_tx_sr[38:0], 1'b0};
                        r_crc     <= crc7_step(r_crc, r_tx_sr[39]);
                    end else if (r_cnt < CW'(47)) begin
                        r_cmd_out <= r_crc[6];
                        r_crc     <= {r_crc[5:0], 1'b0};
                    end else if (r_cnt == CW'(47)) begin
                        r_cmd_out <= 1'b1;
                    end else begin
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
                        r_cnt     <= '0;
                        r_crc     <= '0;
                    end
                end
                // The start bit is 0 and the CRC is 0, so it needs no CRC update
                S_WAIT: if (sdclk_rise_stb_i) begin
                    if (!cmd_in_i) begin
                        r_rx_sr <= {r_rx_sr[134:0], 1'b0};
                        r_cnt   <= CW'(1);
                    end else if (w_cnt_inc == CW'(TIMEOUT_CYC)) begin
                        r_to_err <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                // On the last bit, r_rx_sr[6:0] already holds response bits 7..1
                S_RX: if (sdclk_rise_stb_i) begin
                    r_rx_sr <= {r_rx_sr[134:0], cmd_in_i};
                    r_cnt   <= w_cnt_inc;
                    if (w_crc_win) r_crc <= crc7_step(r_crc, cmd_in_i);
                    if (w_cnt_inc == w_rx_len) begin
                        r_cnt <= '0;
                        if (r_type != 2'b11 && r_crc != r_rx_sr[6:0]) r_crc_err <= 1'b1;
                    end
                end
                S_DONE: r_cnt <= '0;
                S_GAP:  if (sdclk_rise_stb_i) r_cnt <= w_cnt_inc;
                default: r_cnt <= '0;
            endcase
        end
    end

    assign resp_o        = r_rx_sr;
    assign crc_err_o     = r_crc_err;
    assign timeout_err_o = r_to_err;
    assign cmd_oe_o      = r_cmd_oe;
    assign cmd_out_o     = r_cmd_out;
endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: SDCLK = clk/4, a behavioural card answers on CMD,
// every transmitted frame and captured response is compared with hand-built values.
module tb_sd_cmd_phy;
    logic         clk_i;
    logic         rst_i;
    logic         sdclk_fall_stb_i;
    logic         sdclk_rise_stb_i;
    logic         cmd_start_i;
    logic [5:0]   cmd_index_i;
    logic [31:0]  cmd_arg_i;
    logic [1:0]   resp_type_i;
    logic         busy_o;
    logic         done_o;
    logic [135:0] resp_o;
    logic         crc_err_o;
    logic         timeout_err_o;
    logic         cmd_oe_o;
    logic         cmd_out_o;
    logic         cmd_in_i;

    sd_cmd_phy #(.TIMEOUT_CYC(64), .GAP_CYC(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .sdclk_fall_stb_i(sdclk_fall_stb_i), .sdclk_rise_stb_i(sdclk_rise_stb_i),
        .cmd_start_i(cmd_start_i), .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i),
        .resp_type_i(resp_type_i), .busy_o(busy_o), .done_o(done_o), .resp_o(resp_o),
        .crc_err_o(crc_err_o), .timeout_err_o(timeout_err_o),
        .cmd_oe_o(cmd_oe_o), .cmd_out_o(cmd_out_o), .cmd_in_i(cmd_in_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int vectors = 0;
    int miscompares = 0;

    int  ph = 0;
    bit  prev_fall = 0, prev_rise = 0, prev_oe = 0;
    logic [47:0]  tx_bits;
    int  oe_falls, done_cnt, rise_since_end, rise_at_done, gap_rise, gap_at_idle;
    bit  done_seen, idle_seen, tx_end_seen, busy_after_start;
    logic [135:0] last_resp;
    logic last_crc, last_to;
    bit  card_en = 0, card_active = 0;
    logic [135:0] card_bits;
    int  card_len, card_delay, card_cnt, card_idx;

    function automatic logic [6:0] ref_crc7(input logic [127:0] data, input int nbits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = nbits - 1; i >= 0; i--) begin
            c = {c[6:0], 1'b0};
            if (c[7] ^ data[i]) c = c ^ 8'h09;
            c = c & 8'h7F;
        end
        return c[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, ref_crc7({88'h0, h}, 40), 1'b1};
    endfunction

    // One clk_i period: observe DUT at negedge, then drive next strobes and card line
    task automatic step();
        bit f, r;
        @(negedge clk_i);
        if (prev_fall && cmd_oe_o) begin
            tx_bits = {tx_bits[46:0], cmd_out_o};
            oe_falls++;
        end
        if (prev_oe && !cmd_oe_o) begin
            tx_end_seen = 1; rise_since_end = 0;
            if (card_en) begin card_active = 1; card_cnt = card_delay; card_idx = 0; end
        end
        if (prev_rise && tx_end_seen) rise_since_end++;
        if (done_o) begin
            done_cnt++; done_seen = 1; gap_rise = 0;
            last_resp = resp_o; last_crc = crc_err_o; last_to = timeout_err_o;
            rise_at_done = rise_since_end;
        end else if (done_seen && prev_rise) begin
            gap_rise++;
        end
        if (done_seen && !busy_o && !idle_seen) begin idle_seen = 1; gap_at_idle = gap_rise; end
        prev_oe = cmd_oe_o;
        ph = (ph + 1) % 4;
        f = (ph == 0);
        r = (ph == 2);
        if (f && card_active) begin
            if (card_cnt > 0) begin cmd_in_i = 1'b1; card_cnt--; end
            else if (card_idx < card_len) begin cmd_in_i = card_bits[card_len - 1 - card_idx]; card_idx++; end
            else begin cmd_in_i = 1'b1; card_active = 0; end
        end
        sdclk_fall_stb_i = f; sdclk_rise_stb_i = r;
        prev_fall = f; prev_rise = r;
    endtask

    task automatic clear_mon();
        tx_bits = '0; oe_falls = 0; done_cnt = 0; rise_since_end = 0; rise_at_done = -1;
        gap_rise = 0; gap_at_idle = -1; done_seen = 0; idle_seen = 0; tx_end_seen = 0;
        last_resp = '0; last_crc = 1'bx; last_to = 1'bx;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input bit card_on, input logic [135:0] bits, input int len,
                           input int delay, input int inject_at);
        clear_mon();
        card_en = card_on; card_bits = bits; card_len = len; card_delay = delay;
        card_active = 0; cmd_in_i = 1'b1;
        cmd_index_i = idx; cmd_arg_i = arg; resp_type_i = typ; cmd_start_i = 1'b1;
        step();
        busy_after_start = busy_o;
        cmd_start_i = 1'b0;
        for (int i = 1; i <= 3000 && !idle_seen; i++) begin
            if (inject_at != 0 && i == inject_at) begin
                cmd_start_i = 1'b1; cmd_index_i = 6'h3F; cmd_arg_i = 32'hFFFF_FFFF; resp_type_i = 2'b10;
            end else begin
                cmd_start_i = 1'b0;
            end
            step();
        end
        cmd_start_i = 1'b0;
        vectors++;
        if (!idle_seen) begin
            miscompares++;
            $display("FAIL cmd%0d_complete: busy/done never finished within 3000 clk, got done_cnt=%0d expected idle", idx, done_cnt);
        end
    endtask

    task automatic test_reset();
        vectors += 6;
        if (busy_o !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        if (done_o !== 1'b0)        begin miscompares++; $display("FAIL reset_done: got %b expected 0", done_o); end
        if (resp_o !== 136'h0)      begin miscompares++; $display("FAIL reset_resp: got %h expected 0", resp_o); end
        if ({crc_err_o, timeout_err_o} !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b expected 00", {crc_err_o, timeout_err_o}); end
        if (cmd_oe_o !== 1'b0)      begin miscompares++; $display("FAIL reset_oe: got %b expected 0", cmd_oe_o); end
        if (cmd_out_o !== 1'b1)     begin miscompares++; $display("FAIL reset_out: got %b expected 1", cmd_out_o); end
    endtask

    task automatic test_cmd0();
        run_cmd(6'd0, 32'h0, 2'b00, 0, '0, 0, 0, 0);
        vectors += 6;
        if (busy_after_start !== 1'b1) begin miscompares++; $display("FAIL cmd0_busy_rise: got %b expected 1", busy_after_start); end
        if (tx_bits !== 48'h400000000095) begin miscompares++; $display("FAIL cmd0_frame: got %h expected 400000000095", tx_bits); end
        if (oe_falls != 48)   begin miscompares++; $display("FAIL cmd0_oe_len: got %0d expected 48", oe_falls); end
        if (done_cnt != 1)    begin miscompares++; $display("FAIL cmd0_done_pulse: got %0d expected 1", done_cnt); end
        if (gap_at_idle != 8) begin miscompares++; $display("FAIL cmd0_gap: got %0d expected 8", gap_at_idle); end
        if ({last_crc, last_to} !== 2'b00) begin miscompares++; $display("FAIL cmd0_err: got %b expected 00", {last_crc, last_to}); end
    endtask

    task automatic test_cmd8();
        run_cmd(6'd8, 32'h0000_01AA, 2'b01, 1, {88'h0, 48'h08000001AA13}, 48, 5, 0);
        vectors += 5;
        if (tx_bits !== 48'h48000001AA87) begin miscompares++; $display("FAIL cmd8_frame: got %h expected 48000001aa87", tx_bits); end
        if (last_resp !== 136'h08000001AA13) begin miscompares++; $display("FAIL cmd8_resp: got %h expected 08000001aa13", last_resp); end
        if (last_crc !== 1'b0) begin miscompares++; $display("FAIL cmd8_crc_err: got %b expected 0", last_crc); end
        if (last_to !== 1'b0)  begin miscompares++; $display("FAIL cmd8_timeout: got %b expected 0", last_to); end
        if (done_cnt != 1)     begin miscompares++; $display("FAIL cmd8_done_pulse: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_crc_error();
        logic [39:0] r1;
        logic [47:0] rsp;
        r1  = 40'h11_0000_0900;
        rsp = {r1, ref_crc7({88'h0, r1}, 40) ^ 7'h04, 1'b1};
        run_cmd(6'd17, 32'h0, 2'b01, 1, {88'h0, rsp}, 48, 3, 0);
        vectors += 4;
        if (tx_bits !== 48'h510000000055) begin miscompares++; $display("FAIL cmd17_frame: got %h expected 510000000055", tx_bits); end
        if (last_crc !== 1'b1) begin miscompares++; $display("FAIL cmd17_crc_err: got %b expected 1", last_crc); end
        if (last_resp !== {88'h0, rsp}) begin miscompares++; $display("FAIL cmd17_resp: got %h expected %h", last_resp, rsp); end
        if (crc_err_o !== 1'b1) begin miscompares++; $display("FAIL cmd17_crc_hold: got %b expected 1", crc_err_o); end
    endtask

    task automatic test_r2();
        logic [119:0] cid;
        logic [135:0] r2;
        cid = 120'h0353445344313647801234567801AB;
        r2  = {8'h3F, cid, ref_crc7({8'h0, cid}, 120), 1'b1};
        run_cmd(6'd2, 32'h0, 2'b10, 1, r2, 136, 2, 0);
        vectors += 4;
        if (tx_bits !== mk_frame(6'd2, 32'h0)) begin miscompares++; $display("FAIL cmd2_frame: got %h expected %h", tx_bits, mk_frame(6'd2, 32'h0)); end
        if (last_resp !== r2)  begin miscompares++; $display("FAIL cmd2_resp: got %h expected %h", last_resp, r2); end
        if (last_crc !== 1'b0) begin miscompares++; $display("FAIL cmd2_crc_err: got %b expected 0", last_crc); end
        if (last_to !== 1'b0)  begin miscompares++; $display("FAIL cmd2_timeout: got %b expected 0", last_to); end
    endtask

    task automatic test_timeout();
        run_cmd(6'd55, 32'h0, 2'b01, 0, '0, 0, 0, 0);
        vectors += 6;
        if (tx_bits !== mk_frame(6'd55, 32'h0)) begin miscompares++; $display("FAIL cmd55_frame: got %h expected %h", tx_bits, mk_frame(6'd55, 32'h0)); end
        if (last_to !== 1'b1)  begin miscompares++; $display("FAIL cmd55_timeout: got %b expected 1", last_to); end
        if (rise_at_done != 64) begin miscompares++; $display("FAIL cmd55_timeout_edge: got %0d expected 64", rise_at_done); end
        if (last_resp !== 136'h0) begin miscompares++; $display("FAIL cmd55_resp: got %h expected 0", last_resp); end
        if (last_crc !== 1'b0) begin miscompares++; $display("FAIL cmd55_crc_err: got %b expected 0", last_crc); end
        if (timeout_err_o !== 1'b1) begin miscompares++; $display("FAIL cmd55_timeout_hold: got %b expected 1", timeout_err_o); end
    endtask

    task automatic test_back_to_back();
        run_cmd(6'd0, 32'h0, 2'b00, 0, '0, 0, 0, 10);
        vectors += 2;
        if (tx_bits !== 48'h400000000095) begin miscompares++; $display("FAIL ignore_start_frame: got %h expected 400000000095", tx_bits); end
        if (done_cnt != 1) begin miscompares++; $display("FAIL ignore_start_done: got %0d expected 1", done_cnt); end
        run_cmd(6'd8, 32'h0000_01AA, 2'b00, 0, '0, 0, 0, 0);
        vectors += 3;
        if (tx_bits !== 48'h48000001AA87) begin miscompares++; $display("FAIL b2b_frame: got %h expected 48000001aa87", tx_bits); end
        if (last_to !== 1'b0) begin miscompares++; $display("FAIL b2b_err_cleared: got %b expected 0", last_to); end
        if (gap_at_idle != 8) begin miscompares++; $display("FAIL b2b_gap: got %0d expected 8", gap_at_idle); end
    endtask

    task automatic test_reset_mid_rx();
        clear_mon();
        card_en = 1; card_bits = {88'h0, 48'h08000001AA13}; card_len = 48; card_delay = 2;
        cmd_in_i = 1'b1;
        cmd_index_i = 6'd8; cmd_arg_i = 32'h0000_01AA; resp_type_i = 2'b01; cmd_start_i = 1'b1;
        step();
        cmd_start_i = 1'b0;
        for (int i = 0; i < 2000 && !(card_active && card_idx >= 20); i++) step();
        vectors++;
        if (!(card_active && card_idx >= 20)) begin
            miscompares++; $display("FAIL rst_rx_reach: got card_idx=%0d expected >=20", card_idx);
        end
        rst_i = 1'b1;
        step();
        vectors += 6;
        if (busy_o !== 1'b0)   begin miscompares++; $display("FAIL rst_rx_busy: got %b expected 0", busy_o); end
        if (done_o !== 1'b0)   begin miscompares++; $display("FAIL rst_rx_done: got %b expected 0", done_o); end
        if (resp_o !== 136'h0) begin miscompares++; $display("FAIL rst_rx_resp: got %h expected 0", resp_o); end
        if ({crc_err_o, timeout_err_o} !== 2'b00) begin miscompares++; $display("FAIL rst_rx_err: got %b expected 00", {crc_err_o, timeout_err_o}); end
        if (cmd_oe_o !== 1'b0)  begin miscompares++; $display("FAIL rst_rx_oe: got %b expected 0", cmd_oe_o); end
        if (cmd_out_o !== 1'b1) begin miscompares++; $display("FAIL rst_rx_out: got %b expected 1", cmd_out_o); end
        card_active = 0; card_en = 0; cmd_in_i = 1'b1;
        rst_i = 1'b0;
        repeat (4) step();
        run_cmd(6'd0, 32'h0, 2'b00, 0, '0, 0, 0, 0);
        vectors++;
        if (tx_bits !== 48'h400000000095) begin miscompares++; $display("FAIL rst_recover_frame: got %h expected 400000000095", tx_bits); end
    endtask

    initial begin
        rst_i = 1'b1; sdclk_fall_stb_i = 1'b0; sdclk_rise_stb_i = 1'b0;
        cmd_start_i = 1'b0; cmd_index_i = '0; cmd_arg_i = '0; resp_type_i = '0; cmd_in_i = 1'b1;
        clear_mon();
        repeat (3) step();
        rst_i = 1'b0;
        step();
        test_reset();
        test_cmd0();
        test_cmd8();
        test_crc_error();
        test_r2();
        test_timeout();
        test_back_to_back();
        test_reset_mid_rx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
